// File: rtl/if_id_hazard_stage.sv
// if_id_hazard_stage: fetch-side front end of a 5-stage MIPS pipeline.
//   Owns the PC and the IF/ID pipeline register and selects the next PC from PCsrc.
//   It detects load-use and branch-operand hazards and, while one is present, holds IF.
//   It flushes the fetched instruction when a branch is taken or a jump is decoded.
// Ports:
//   clk, rst           clock; asynchronous active-high reset
//   instrIn            instruction memory data for address pc
//   PCsrc              0 seq, 1 branch taken, 2 jump, 3 reserved (treated as seq)
//   exMemRead, exRegWrite, exWriteReg   ID/EX stage hazard sources
//   memMemRead, memWriteReg             EX/MEM stage hazard sources
//   pc                 fetch address
//   ifidInstr, ifidPcPlus4              IF/ID register contents
//   opcode/func/rs/rt/rd/imm16          decoded IF/ID fields
//   nopOut             1 = control unit must treat IF/ID as a bubble
//   stall              hazard stall; PC and IF/ID hold this cycle
module if_id_hazard_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instrIn,
  input  logic [1:0]  PCsrc,
  input  logic        exMemRead,
  input  logic        exRegWrite,
  input  logic [4:0]  exWriteReg,
  input  logic        memMemRead,
  input  logic [4:0]  memWriteReg,
  output logic [31:0] pc,
  output logic [31:0] ifidInstr,
  output logic [31:0] ifidPcPlus4,
  output logic [5:0]  opcode,
  output logic [5:0]  func,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [15:0] imm16,
  output logic        nopOut,
  output logic        stall
);

  localparam logic [5:0] OpRType = 6'b000000;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpBne   = 6'b000101;
  localparam logic [5:0] OpSw    = 6'b101011;

  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pcp4_q, pcp4_d;
  logic        valid_q, valid_d;

  logic        uses_rt, is_branch;
  logic        ex_match, mem_match;
  logic        haz_load_use, haz_br_alu, haz_br_load;
  logic [31:0] pc_plus4, br_target, j_target;

  assign opcode = instr_q[31:26];
  assign rs     = instr_q[25:21];
  assign rt     = instr_q[20:16];
  assign rd     = instr_q[15:11];
  assign func   = instr_q[5:0];
  assign imm16  = instr_q[15:0];

  assign uses_rt   = (opcode == OpRType) || (opcode == OpBeq) || (opcode == OpBne) ||
                     (opcode == OpSw);
  assign is_branch = (opcode == OpBeq) || (opcode == OpBne);

  // Register 0 is hardwired, so a write to it never creates a dependency.
  assign ex_match  = (exWriteReg != 5'd0) &&
                     ((exWriteReg == rs) || (uses_rt && (exWriteReg == rt)));
  assign mem_match = (memWriteReg != 5'd0) &&
                     ((memWriteReg == rs) || (uses_rt && (memWriteReg == rt)));

  // An empty IF/ID slot has no operands, so it can never be hazarded.
  assign haz_load_use = valid_q && exMemRead && ex_match;
  assign haz_br_alu   = valid_q && is_branch && exRegWrite && ex_match;
  assign haz_br_load  = valid_q && is_branch && memMemRead && mem_match;
  assign stall        = haz_load_use || haz_br_alu || haz_br_load;
  assign nopOut       = !valid_q || stall;

  assign pc_plus4  = pc_q + 32'd4;
  assign br_target = pcp4_q + {{14{instr_q[15]}}, instr_q[15:0], 2'b00};
  assign j_target  = {pcp4_q[31:28], instr_q[25:0], 2'b00};

  always_comb begin
    pc_d    = pc_q;
    instr_d = instr_q;
    pcp4_d  = pcp4_q;
    valid_d = valid_q;
    if (stall) begin
      // hold everything
    end else if (PCsrc == 2'd1 || PCsrc == 2'd2) begin
      pc_d    = (PCsrc == 2'd1) ? br_target : j_target;
      instr_d = 32'd0;
      pcp4_d  = pc_plus4;
      valid_d = 1'b0;
    end else begin
      pc_d    = pc_plus4;
      instr_d = instrIn;
      pcp4_d  = pc_plus4;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q    <= RESET_PC;
      instr_q <= 32'd0;
      pcp4_q  <= 32'd0;
      valid_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pcp4_q  <= pcp4_d;
      valid_q <= valid_d;
    end
  end

  assign pc          = pc_q;
  assign ifidInstr   = instr_q;
  assign ifidPcPlus4 = pcp4_q;

endmodule

// File: tb/tb_if_id_hazard_stage.sv
module tb_if_id_hazard_stage;

  localparam logic [31:0] Nop20 = 32'h0000_0020;  // add $0,$0,$0
  localparam logic [31:0] Add   = 32'h0044_1820;  // add $3,$2,$4
  localparam logic [31:0] Beq1  = 32'h10A6_0003;  // beq $5,$6,+3
  localparam logic [31:0] Beq2  = 32'h1021_FFFB;  // beq $1,$1,-5
  localparam logic [31:0] Beq3  = 32'h1000_8000;  // beq $0,$0,-32768
  localparam logic [31:0] Beq4  = 32'h1000_FFFF;  // beq $0,$0,-1
  localparam logic [31:0] J10   = 32'h0800_0004;  // j 0x10
  localparam logic [31:0] JTop  = 32'h0BFF_FFFF;  // j field all ones
  localparam logic [31:0] J3c   = 32'h0800_000F;  // j 0x3C
  localparam logic [31:0] J40   = 32'h0800_0040;  // j field 0x40

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instrIn;
  logic [1:0]  PCsrc;
  logic        exMemRead, exRegWrite, memMemRead;
  logic [4:0]  exWriteReg, memWriteReg;

  logic [31:0] pc1, instr1, pcp41, pc2, instr2, pcp42;
  logic [5:0]  opcode1, func1, opcode2, func2;
  logic [4:0]  rs1, rt1, rd1, rs2, rt2, rd2;
  logic [15:0] imm1, imm2;
  logic        nop1, stall1, nop2, stall2;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int          unit;
    string       name;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] pcp4;
    bit          chk_pcp4;
    logic        nop;
    logic        stall;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  if_id_hazard_stage dut (
    .clk(clk), .rst(rst), .instrIn(instrIn), .PCsrc(PCsrc),
    .exMemRead(exMemRead), .exRegWrite(exRegWrite), .exWriteReg(exWriteReg),
    .memMemRead(memMemRead), .memWriteReg(memWriteReg),
    .pc(pc1), .ifidInstr(instr1), .ifidPcPlus4(pcp41), .opcode(opcode1), .func(func1),
    .rs(rs1), .rt(rt1), .rd(rd1), .imm16(imm1), .nopOut(nop1), .stall(stall1)
  );

  // Second instance with a high reset vector, for the jump that keeps pc+4's top nibble.
  if_id_hazard_stage #(.RESET_PC(32'h1000_0004)) dut_hi (
    .clk(clk), .rst(rst), .instrIn(instrIn), .PCsrc(PCsrc),
    .exMemRead(exMemRead), .exRegWrite(exRegWrite), .exWriteReg(exWriteReg),
    .memMemRead(memMemRead), .memWriteReg(memWriteReg),
    .pc(pc2), .ifidInstr(instr2), .ifidPcPlus4(pcp42), .opcode(opcode2), .func(func2),
    .rs(rs2), .rt(rt2), .rd(rd2), .imm16(imm2), .nopOut(nop2), .stall(stall2)
  );

  task automatic cmp(input string n, input string f, input logic [31:0] act,
                     input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s.%s: got %h, required %h", n, f, act, req);
    end
  endtask

  // Monitor: outputs are presented every cycle; check all pending expectations mid-cycle.
  always @(negedge clk) begin
    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      if (e.unit == 1) begin
        cmp(e.name, "pc", pc1, e.pc);
        cmp(e.name, "ifidInstr", instr1, e.instr);
        if (e.chk_pcp4) cmp(e.name, "ifidPcPlus4", pcp41, e.pcp4);
        cmp(e.name, "nopOut", {31'd0, nop1}, {31'd0, e.nop});
        cmp(e.name, "stall", {31'd0, stall1}, {31'd0, e.stall});
        cmp(e.name, "opcode", {26'd0, opcode1}, {26'd0, e.instr[31:26]});
        cmp(e.name, "rs", {27'd0, rs1}, {27'd0, e.instr[25:21]});
        cmp(e.name, "imm16", {16'd0, imm1}, {16'd0, e.instr[15:0]});
      end else begin
        cmp(e.name, "hi.pc", pc2, e.pc);
        cmp(e.name, "hi.ifidInstr", instr2, e.instr);
        if (e.chk_pcp4) cmp(e.name, "hi.ifidPcPlus4", pcp42, e.pcp4);
        cmp(e.name, "hi.nopOut", {31'd0, nop2}, {31'd0, e.nop});
      end
    end
  end

  task automatic expect_out(input int unit, input string n, input logic [31:0] p,
                            input logic [31:0] i, input logic [31:0] p4, input bit c4,
                            input logic nop, input logic st);
    exp_t e;
    e.unit = unit; e.name = n; e.pc = p; e.instr = i; e.pcp4 = p4; e.chk_pcp4 = c4;
    e.nop = nop; e.stall = st;
    sb.push_back(e);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; instrIn = Nop20; PCsrc = 2'd0;
    exMemRead = 1'b0; exRegWrite = 1'b0; exWriteReg = 5'd0;
    memMemRead = 1'b0; memWriteReg = 5'd0;
    next_cycle();

    // Reset state and free run
    expect_out(1, "reset", 32'h0, 32'h0, 32'h0, 1, 1, 0);
    expect_out(2, "reset_hi", 32'h1000_0004, 32'h0, 32'h0, 1, 1, 0);
    next_cycle();
    rst = 1'b0;
    expect_out(1, "run0", 32'h0, 32'h0, 32'h0, 1, 1, 0);
    next_cycle();
    expect_out(1, "run1", 32'h4, Nop20, 32'h4, 1, 0, 0);
    next_cycle();
    instrIn = Add;
    expect_out(1, "run2", 32'h8, Nop20, 32'h8, 1, 0, 0);
    next_cycle();

    // Load-use on rs, then on rt, then $0 never hazards
    instrIn = Nop20; exMemRead = 1'b1; exWriteReg = 5'd2;
    expect_out(1, "lu_rs", 32'hC, Add, 32'hC, 1, 1, 1);
    next_cycle();
    exWriteReg = 5'd4;
    expect_out(1, "lu_rt", 32'hC, Add, 32'hC, 1, 1, 1);
    next_cycle();
    exWriteReg = 5'd0; instrIn = Beq1;
    expect_out(1, "lu_r0", 32'hC, Add, 32'hC, 1, 0, 0);
    next_cycle();

    // Branch after ALU, then branch after load in MEM
    instrIn = Nop20; exMemRead = 1'b0; exRegWrite = 1'b1; exWriteReg = 5'd5;
    expect_out(1, "br_alu", 32'h10, Beq1, 32'h10, 1, 1, 1);
    next_cycle();
    exRegWrite = 1'b0; memMemRead = 1'b1; memWriteReg = 5'd5;
    expect_out(1, "br_mem", 32'h10, Beq1, 32'h10, 1, 1, 1);
    next_cycle();
    memMemRead = 1'b0; exRegWrite = 1'b1; exWriteReg = 5'd7; PCsrc = 2'd1;
    expect_out(1, "br_nomatch", 32'h10, Beq1, 32'h10, 1, 0, 0);
    next_cycle();

    // Taken forward branch: 0x10 + 12
    exRegWrite = 1'b0; PCsrc = 2'd0; instrIn = J10;
    expect_out(1, "br_fwd", 32'h1C, 32'h0, 32'h0, 0, 1, 0);
    next_cycle();
    PCsrc = 2'd2;
    expect_out(1, "j_pre", 32'h20, J10, 32'h20, 1, 0, 0);
    next_cycle();
    PCsrc = 2'd0; instrIn = Beq2;
    expect_out(1, "j_0x10", 32'h10, 32'h0, 32'h0, 0, 1, 0);
    next_cycle();
    PCsrc = 2'd1;
    expect_out(1, "beq_back_pre", 32'h14, Beq2, 32'h14, 1, 0, 0);
    next_cycle();
    PCsrc = 2'd0; instrIn = Beq3;
    expect_out(1, "beq_back", 32'h0, 32'h0, 32'h0, 0, 1, 0);
    next_cycle();

    // Reach the top of the address space and wrap
    PCsrc = 2'd1;
    expect_out(1, "far_pre", 32'h4, Beq3, 32'h4, 1, 0, 0);
    next_cycle();
    PCsrc = 2'd0; instrIn = JTop;
    expect_out(1, "far_back", 32'hFFFE_0004, 32'h0, 32'h0, 0, 1, 0);
    next_cycle();
    PCsrc = 2'd2;
    expect_out(1, "jtop_pre", 32'hFFFE_0008, JTop, 32'hFFFE_0008, 1, 0, 0);
    next_cycle();
    PCsrc = 2'd0; instrIn = Nop20;
    expect_out(1, "jtop", 32'hFFFF_FFFC, 32'h0, 32'h0, 0, 1, 0);
    next_cycle();
    instrIn = Beq4;
    expect_out(1, "wrap", 32'h0, Nop20, 32'h0, 1, 0, 0);
    next_cycle();
    PCsrc = 2'd1;
    expect_out(1, "m1_pre", 32'h4, Beq4, 32'h4, 1, 0, 0);
    next_cycle();
    PCsrc = 2'd0; instrIn = J3c;
    expect_out(1, "imm_m1", 32'h0, 32'h0, 32'h0, 0, 1, 0);
    next_cycle();
    PCsrc = 2'd2;
    expect_out(1, "j3c_pre", 32'h4, J3c, 32'h4, 1, 0, 0);
    next_cycle();
    PCsrc = 2'd0; instrIn = Add;
    expect_out(1, "j3c", 32'h3C, 32'h0, 32'h0, 0, 1, 0);
    next_cycle();

    // Reset in the middle of a stall at pc 0x40
    instrIn = Nop20; exMemRead = 1'b1; exWriteReg = 5'd2;
    expect_out(1, "stall40", 32'h40, Add, 32'h40, 1, 1, 1);
    next_cycle();
    rst = 1'b1;
    expect_out(1, "rst_stall", 32'h0, 32'h0, 32'h0, 1, 1, 0);
    expect_out(2, "rst_stall_hi", 32'h1000_0004, 32'h0, 32'h0, 1, 1, 0);
    next_cycle();
    rst = 1'b0; exMemRead = 1'b0; instrIn = J40;
    expect_out(1, "post_rst", 32'h0, 32'h0, 32'h0, 1, 1, 0);
    next_cycle();
    PCsrc = 2'd2;
    expect_out(1, "post_rst_valid", 32'h4, J40, 32'h4, 1, 0, 0);
    expect_out(2, "jhi_pre", 32'h1000_0008, J40, 32'h1000_0008, 1, 0, 0);
    next_cycle();
    PCsrc = 2'd0;
    expect_out(1, "j_0x100", 32'h100, 32'h0, 32'h0, 0, 1, 0);
    expect_out(2, "jhi", 32'h1000_0100, 32'h0, 32'h0, 0, 1, 0);
    next_cycle();

    @(negedge clk);
    #1;
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: got %0d pending, required 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
